// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU requester path.
//   - ALU control codes (4-bit, 0..11)
//   - ALUOp encodings from the main decoder
//   - R-type funct values understood by the ALU
//   - issue FSM state encoding and the op-decode result struct
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_NAND  = 4'd2;
  localparam logic [3:0] ALU_NOR   = 4'd3;
  localparam logic [3:0] ALU_ADDU  = 4'd4;
  localparam logic [3:0] ALU_SUBU  = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_EQUAL = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SRAV  = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_SLTU  = 4'd11;

  localparam logic [2:0] OP_ADDU  = 3'b000;
  localparam logic [2:0] OP_SUBU  = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_SLT   = 3'b011;
  localparam logic [2:0] OP_LUI   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_SLTU  = 3'b110;
  localparam logic [2:0] OP_BEQ   = 3'b111; // compare via subtract

  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Which value feeds ALU src1; src2 is always rt / extended immediate.
  typedef enum logic [1:0] {
    SRC1_RS,
    SRC1_SHAMT,
    SRC1_RS_LO5,
    SRC1_ZERO
  } src1_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    src1_sel_e  src1_sel;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU and response signals of alu_issue_ctrl.
//   req_*  : valid/ready request from decode (ALUOp, funct, shamt, rs, rt)
//   alu_*  : operands/ctrl to the combinational ALU and its result/zero
//   resp_* : valid/ready response carrying result, zero and illegal flag
// slave  = the issue controller, master = the decode stage / ALU side.
interface alu_issue_ctrl_if #(
  parameter int DW = 32,
  parameter int CW = 4
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [2:0]    req_aluop_i;
  logic [5:0]    req_funct_i;
  logic [4:0]    req_shamt_i;
  logic [DW-1:0] req_rs_i;
  logic [DW-1:0] req_rt_i;
  logic [DW-1:0] alu_src1_o;
  logic [DW-1:0] alu_src2_o;
  logic [CW-1:0] alu_ctrl_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_result_o;
  logic          resp_zero_o;
  logic          resp_illegal_o;

  modport slave (
    input  req_valid_i, req_aluop_i, req_funct_i, req_shamt_i, req_rs_i, req_rt_i,
           alu_result_i, alu_zero_i, resp_ready_i,
    output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
           resp_valid_o, resp_result_o, resp_zero_o, resp_illegal_o
  );

  modport master (
    output req_valid_i, req_aluop_i, req_funct_i, req_shamt_i, req_rs_i, req_rt_i,
           alu_result_i, alu_zero_i, resp_ready_i,
    input  req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
           resp_valid_o, resp_result_o, resp_zero_o, resp_illegal_o
  );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALUOp/funct -> {ALU ctrl, src1 select, illegal}.
// No state, so it can be dropped into a single-cycle datapath as-is.
//   aluop_i : ALUOp from the main decoder
//   funct_i : R-type funct field (only consulted for ALUOp=010)
//   dec_o   : decoded control, src1 selection and illegal flag
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{ctrl: ALU_ADDU, src1_sel: SRC1_RS, illegal: 1'b0};
    case (aluop_i)
      OP_ADDU: dec_o.ctrl = ALU_ADDU;
      OP_SUBU,
      OP_BEQ:  dec_o.ctrl = ALU_SUBU;
      OP_SLT:  dec_o.ctrl = ALU_SLT;
      OP_LUI:  begin dec_o.ctrl = ALU_LUI; dec_o.src1_sel = SRC1_ZERO; end
      OP_OR:   dec_o.ctrl = ALU_OR;
      OP_SLTU: dec_o.ctrl = ALU_SLTU;
      default: begin // OP_RTYPE
        case (funct_i)
          FN_ADDU: dec_o.ctrl = ALU_ADDU;
          FN_SUBU: dec_o.ctrl = ALU_SUBU;
          FN_AND:  dec_o.ctrl = ALU_AND;
          FN_OR:   dec_o.ctrl = ALU_OR;
          FN_NOR:  dec_o.ctrl = ALU_NOR;
          FN_SLT:  dec_o.ctrl = ALU_SLT;
          FN_SLTU: dec_o.ctrl = ALU_SLTU;
          FN_SRA:  begin dec_o.ctrl = ALU_SRA;  dec_o.src1_sel = SRC1_SHAMT;  end
          FN_SRAV: begin dec_o.ctrl = ALU_SRAV; dec_o.src1_sel = SRC1_RS_LO5; end
          default: dec_o.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester side of the multi-cycle ALU.
// Accepts one decoded op at a time, drives registered src1/src2/ctrl into the
// combinational ALU for one cycle, captures result/zero and returns them on a
// valid/ready response. Unsupported ALUOp/funct answer immediately as illegal.
//   clk_i, rst_n : clock, synchronous active-low reset
//   bus          : alu_issue_ctrl_if slave (req_*, alu_*, resp_*)
// Timing: legal accept at edge N -> resp_valid at N+2; illegal -> N+1.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus
);

  dec_t          dec;
  logic [DW-1:0] src1_d;

  state_e        state_q;
  logic          req_ready_q;
  logic [DW-1:0] src1_q, src2_q;
  logic [CW-1:0] ctrl_q;
  logic          resp_valid_q;
  logic [DW-1:0] resp_result_q;
  logic          resp_zero_q;
  logic          resp_illegal_q;

  alu_op_decode u_dec (
    .aluop_i (bus.req_aluop_i),
    .funct_i (bus.req_funct_i),
    .dec_o   (dec)
  );

  always_comb begin
    src1_d = bus.req_rs_i;
    case (dec.src1_sel)
      SRC1_SHAMT:  src1_d = {{(DW-5){1'b0}}, bus.req_shamt_i};
      SRC1_RS_LO5: src1_d = {{(DW-5){1'b0}}, bus.req_rs_i[4:0]};
      SRC1_ZERO:   src1_d = '0;
      default:     src1_d = bus.req_rs_i;
    endcase
  end

  // All outputs are registered here; alu_* only change on a legal accept so
  // the ALU never sees a spurious ctrl change.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b1;
      src1_q         <= '0;
      src2_q         <= '0;
      ctrl_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_result_q  <= '0;
      resp_zero_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            req_ready_q <= 1'b0;
            if (dec.illegal) begin
              resp_illegal_q <= 1'b1;
              resp_result_q  <= '0;
              resp_zero_q    <= 1'b0;
              resp_valid_q   <= 1'b1;
              state_q        <= ST_RESP;
            end else begin
              src1_q  <= src1_d;
              src2_q  <= bus.req_rt_i;
              ctrl_q  <= CW'(dec.ctrl);
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // Operands have been stable for a full cycle; ALU output is settled.
          resp_result_q  <= bus.alu_result_i;
          resp_zero_q    <= bus.alu_zero_i;
          resp_illegal_q <= 1'b0;
          resp_valid_q   <= 1'b1;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin // ST_CAPTURE is reserved: recover to IDLE
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o    = req_ready_q;
  assign bus.alu_src1_o     = src1_q;
  assign bus.alu_src2_o     = src2_q;
  assign bus.alu_ctrl_o     = ctrl_q;
  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.resp_result_o  = resp_result_q;
  assign bus.resp_zero_o    = resp_zero_q;
  assign bus.resp_illegal_o = resp_illegal_q;

endmodule
